// File: rtl/down_counter.sv
// Loadable down counter with terminal-count pulse, IDLE/RUN/DONE sequencing and auto-reload.
// Define DOWN_CNT_EVT_CNT_EN to add the saturating 8-bit terminal-count event counter (evt_cnt).
module down_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] cnt,
    output logic             tc,
    output logic             busy,
    output logic             done
`ifdef DOWN_CNT_EVT_CNT_EN
    ,
    output logic [7:0]       evt_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0] CNT_ZERO = '0;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] cnt_reg, cnt_next;
    logic [WIDTH-1:0] reload_reg, reload_next;
    logic             tc_reg, tc_next;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            reload_reg <= '0;
            tc_reg     <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            reload_reg <= reload_next;
            tc_reg     <= tc_next;
        end
    end

    // Load overrides counting, so a load on the terminal cycle suppresses tc.
    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        reload_next = reload_reg;
        tc_next     = 1'b0;
        if (load) begin
            reload_next = load_val;
            cnt_next    = load_val;
            state_next  = (load_val != CNT_ZERO) ? RUN : IDLE;
        end else begin
            case (state_reg)
                RUN: begin
                    if (en) begin
                        if (cnt_reg == CNT_ONE) begin
                            tc_next = 1'b1;
                            if (auto_reload) begin
                                cnt_next = reload_reg;
                            end else begin
                                cnt_next   = CNT_ZERO;
                                state_next = DONE;
                            end
                        end else begin
                            cnt_next = cnt_reg - CNT_ONE;
                        end
                    end
                end
                default: begin
                    // IDLE and DONE ignore en and hold until load or reset.
                end
            endcase
        end
    end

    assign cnt  = cnt_reg;
    assign tc   = tc_reg;
    assign busy = (state_reg == RUN);
    assign done = (state_reg == DONE);

`ifdef DOWN_CNT_EVT_CNT_EN
    logic [7:0] evt_reg, evt_next;

    always_comb begin
        evt_next = evt_reg;
        if (tc_next && (evt_reg != 8'hFF)) begin
            evt_next = evt_reg + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            evt_reg <= 8'd0;
        end else begin
            evt_reg <= evt_next;
        end
    end

    assign evt_cnt = evt_reg;
`endif

endmodule

// File: tb/tb_down_counter.sv
// Directed self-checking bench for down_counter; each task drives one scenario and checks inline.
// Build with DOWN_CNT_EVT_CNT_EN defined to also check the event counter.
module tb_down_counter;

    localparam int WIDTH = 32;

    logic             clk;
    logic             rst_n;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             en;
    logic             auto_reload;
    logic [WIDTH-1:0] cnt;
    logic             tc;
    logic             busy;
    logic             done;
`ifdef DOWN_CNT_EVT_CNT_EN
    logic [7:0]       evt_cnt;
`endif

    int errors = 0;
    int checks = 0;

    down_counter #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (load),
        .load_val    (load_val),
        .en          (en),
        .auto_reload (auto_reload),
        .cnt         (cnt),
        .tc          (tc),
        .busy        (busy),
        .done        (done)
`ifdef DOWN_CNT_EVT_CNT_EN
        ,
        .evt_cnt     (evt_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle; outputs then reflect that edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        load  = 1'b0;
        en    = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic do_load(input logic [WIDTH-1:0] v);
        load     = 1'b1;
        load_val = v;
        step();
        load     = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (cnt !== '0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", cnt); end
        checks++; if (tc !== 1'b0) begin errors++; $display("FAIL reset_tc: got %b expected 0", tc); end
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_state: busy=%b done=%b expected 0/0", busy, done); end
`ifdef DOWN_CNT_EVT_CNT_EN
        checks++; if (evt_cnt !== 8'd0) begin errors++; $display("FAIL reset_evt: got %0d expected 0", evt_cnt); end
`endif
        en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if (cnt !== '0 || tc !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
                errors++;
                $display("FAIL idle_en cycle %0d: cnt=%0d tc=%b busy=%b done=%b expected 0/0/0/0", i, cnt, tc, busy, done);
            end
        end
        $display("test_reset: done");
    endtask

    task automatic test_oneshot();
        auto_reload = 1'b0;
        en = 1'b0;
        do_load(5);
        checks++; if (cnt !== 32'd5 || busy !== 1'b1 || tc !== 1'b0) begin errors++; $display("FAIL oneshot_load: cnt=%0d busy=%b tc=%b expected 5/1/0", cnt, busy, tc); end
        en = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            step();
            checks++;
            if (cnt !== 32'(5 - i) || tc !== (i == 5) || busy !== (i < 5) || done !== (i == 5)) begin
                errors++;
                $display("FAIL oneshot_step %0d: cnt=%0d tc=%b busy=%b done=%b expected %0d/%b/%b/%b",
                         i, cnt, tc, busy, done, 5 - i, (i == 5), (i < 5), (i == 5));
            end
        end
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (cnt !== '0 || tc !== 1'b0 || busy !== 1'b0 || done !== 1'b1) begin
                errors++;
                $display("FAIL oneshot_hold %0d: cnt=%0d tc=%b busy=%b done=%b expected 0/0/0/1", i, cnt, tc, busy, done);
            end
        end
        $display("test_oneshot: done");
    endtask

    task automatic test_auto_reload();
        int pulses;
        int exp_cnt;
        pulses = 0;
        do_reset();
        auto_reload = 1'b1;
        do_load(3);
        checks++; if (cnt !== 32'd3) begin errors++; $display("FAIL reload_load: got %0d expected 3", cnt); end
        en = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step();
            exp_cnt = (k % 3 == 0) ? 3 : 3 - (k % 3);
            if (tc === 1'b1) pulses++;
            checks++;
            if (cnt !== 32'(exp_cnt) || tc !== (k % 3 == 0) || busy !== 1'b1) begin
                errors++;
                $display("FAIL reload_step %0d: cnt=%0d tc=%b busy=%b expected %0d/%b/1", k, cnt, tc, busy, exp_cnt, (k % 3 == 0));
            end
        end
        checks++; if (pulses != 4) begin errors++; $display("FAIL reload_pulses: got %0d expected 4", pulses); end
`ifdef DOWN_CNT_EVT_CNT_EN
        checks++; if (evt_cnt !== 8'd4) begin errors++; $display("FAIL reload_evt: got %0d expected 4", evt_cnt); end
`endif
        // Reload value of 1 gives a tc every enabled cycle.
        do_load(1);
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if (cnt !== 32'd1 || tc !== 1'b1 || busy !== 1'b1) begin
                errors++;
                $display("FAIL reload_one %0d: cnt=%0d tc=%b busy=%b expected 1/1/1", k, cnt, tc, busy);
            end
        end
`ifdef DOWN_CNT_EVT_CNT_EN
        checks++; if (evt_cnt !== 8'd7) begin errors++; $display("FAIL reload_one_evt: got %0d expected 7", evt_cnt); end
        for (int k = 0; k < 300; k++) step();
        checks++; if (evt_cnt !== 8'd255) begin errors++; $display("FAIL evt_saturate: got %0d expected 255", evt_cnt); end
        do_load(2);
        checks++; if (evt_cnt !== 8'd255) begin errors++; $display("FAIL evt_load_keeps: got %0d expected 255", evt_cnt); end
`endif
        auto_reload = 1'b0;
        $display("test_auto_reload: done");
    endtask

    task automatic test_enable_gap();
        logic [5:0]  en_seq;
        int          exp_seq [6];
        en_seq  = 6'b111001;  // applied LSB first: 1,0,0,1,1,1
        exp_seq = '{3, 3, 3, 2, 1, 0};
        auto_reload = 1'b0;
        en = 1'b0;
        do_load(4);
        checks++; if (cnt !== 32'd4) begin errors++; $display("FAIL gap_load: got %0d expected 4", cnt); end
        for (int i = 0; i < 6; i++) begin
            en = en_seq[i];
            step();
            checks++;
            if (cnt !== 32'(exp_seq[i]) || tc !== (i == 5)) begin
                errors++;
                $display("FAIL gap_step %0d: cnt=%0d tc=%b expected %0d/%b", i, cnt, tc, exp_seq[i], (i == 5));
            end
        end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL gap_done: got %b expected 1", done); end
        $display("test_enable_gap: done");
    endtask

    task automatic test_load_on_terminal();
`ifdef DOWN_CNT_EVT_CNT_EN
        logic [7:0] evt_before;
`endif
        do_reset();
        auto_reload = 1'b0;
        do_load(2);
        en = 1'b1;
        step();
        checks++; if (cnt !== 32'd1) begin errors++; $display("FAIL term_pre: got %0d expected 1", cnt); end
`ifdef DOWN_CNT_EVT_CNT_EN
        evt_before = evt_cnt;
`endif
        do_load(7);
        checks++; if (cnt !== 32'd7 || tc !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL term_load: cnt=%0d tc=%b busy=%b expected 7/0/1", cnt, tc, busy); end
`ifdef DOWN_CNT_EVT_CNT_EN
        checks++; if (evt_cnt !== evt_before) begin errors++; $display("FAIL term_evt: got %0d expected %0d", evt_cnt, evt_before); end
`endif
        load_val = 32'd99;
        step();
        checks++; if (cnt !== 32'd6) begin errors++; $display("FAIL term_ignore_val: got %0d expected 6", cnt); end
        do_load(0);
        checks++; if (cnt !== '0 || busy !== 1'b0 || done !== 1'b0 || tc !== 1'b0) begin errors++; $display("FAIL load_zero: cnt=%0d busy=%b done=%b tc=%b expected 0/0/0/0", cnt, busy, done, tc); end
        step();
        checks++; if (cnt !== '0 || busy !== 1'b0 || tc !== 1'b0) begin errors++; $display("FAIL load_zero_hold: cnt=%0d busy=%b tc=%b expected 0/0/0", cnt, busy, tc); end
        $display("test_load_on_terminal: done");
    endtask

    task automatic test_reset_mid();
        auto_reload = 1'b0;
        do_load(20);
        en = 1'b1;
        for (int i = 0; i < 11; i++) step();
        checks++; if (cnt !== 32'd9) begin errors++; $display("FAIL mid_pre: got %0d expected 9", cnt); end
        // Low pulse entirely between edges must be ignored.
        #1 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        step();
        checks++; if (cnt !== 32'd8 || busy !== 1'b1) begin errors++; $display("FAIL mid_glitch: cnt=%0d busy=%b expected 8/1", cnt, busy); end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        checks++; if (cnt !== '0 || busy !== 1'b0 || done !== 1'b0 || tc !== 1'b0) begin errors++; $display("FAIL mid_reset: cnt=%0d busy=%b done=%b tc=%b expected 0/0/0/0", cnt, busy, done, tc); end
`ifdef DOWN_CNT_EVT_CNT_EN
        checks++; if (evt_cnt !== 8'd0) begin errors++; $display("FAIL mid_reset_evt: got %0d expected 0", evt_cnt); end
`endif
        step();
        checks++; if (cnt !== '0 || busy !== 1'b0) begin errors++; $display("FAIL mid_after: cnt=%0d busy=%b expected 0/0", cnt, busy); end
        $display("test_reset_mid: done");
    endtask

    initial begin
        rst_n       = 1'b0;
        load        = 1'b0;
        load_val    = '0;
        en          = 1'b0;
        auto_reload = 1'b0;
        test_reset();
        test_oneshot();
        test_auto_reload();
        test_enable_gap();
        test_load_on_terminal();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
